// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults for the instruction fetch queue: depth, reset PC and PC step.
package if_fetch_queue_pkg;
    localparam int          IF_QUEUE_DEPTH = 4;
    localparam logic [31:0] IF_RESET_PC    = 32'h0000_0000;
    localparam int          INST_STEP      = 4;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count; caller never pushes when full.
module sync_fifo #(
    parameter int   WIDTH = 32,
    parameter int   DEPTH = 4,
    localparam int  CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && !flush_i;
    assign w_pop   = pop_i && !flush_i && (r_count != '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/if_fetch_queue.sv
// IF stage: credit-limited req/gnt fetch, {pc,inst} queue, redirect with in-flight discard.
// Optional IF_PERF_CNT_EN adds popped-instruction and empty-cycle counters.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               INST_W   = 32,
    parameter int               DEPTH    = IF_QUEUE_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              stall_req_o
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_empty_cnt_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        r_fetch_pc;
    logic [CW-1:0]            r_outstanding;
    logic [CW-1:0]            r_discard;
    logic [CW-1:0]            w_count;
    logic [CW-1:0]            w_pc_count;
    logic [CW-1:0]            w_out_next;
    logic [ADDR_W-1:0]        w_rsp_pc;
    logic [ADDR_W+INST_W-1:0] w_head;
    logic                     w_credit;
    logic                     w_grant;
    logic                     w_rsp;
    logic                     w_keep;
    logic                     w_pop;

    // Queue entries plus in-flight requests may never exceed DEPTH, so a response always has room.
    assign w_credit   = ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign mem_req_o  = rst && w_credit;
    assign mem_addr_o = r_fetch_pc;
    assign w_grant    = mem_req_o && mem_gnt_i;
    assign w_rsp      = mem_rvalid_i && (r_outstanding != '0);
    assign w_keep     = w_rsp && (r_discard == '0) && !branch_i;
    assign w_pop      = valid_o && ready_i && !branch_i;
    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(w_rsp);

    assign valid_o     = (w_count != '0);
    assign pc_o        = valid_o ? w_head[ADDR_W+INST_W-1:INST_W] : '0;
    assign inst_o      = valid_o ? w_head[INST_W-1:0] : '0;
    assign stall_req_o = !valid_o;

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_grant),
        .push_data_i (r_fetch_pc),
        .pop_i       (w_rsp),
        .flush_i     (1'b0),
        .head_o      (w_rsp_pc),
        .count_o     (w_pc_count)
    );

    sync_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_keep),
        .push_data_i ({w_rsp_pc, mem_rdata_i}),
        .pop_i       (w_pop),
        .flush_i     (branch_i),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    // On redirect everything still in flight after this edge belongs to the old stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (branch_i) begin
                r_discard  <= w_out_next;
                r_fetch_pc <= branch_target_i;
            end else begin
                if (w_rsp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
                if (w_grant) r_fetch_pc <= r_fetch_pc + ADDR_W'(INST_STEP);
            end
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
        mem_rvalid_i |-> (r_outstanding != '0));
    a_pc_fifo_tracks: assert property (@(posedge clk) disable iff (!rst)
        w_pc_count == r_outstanding);

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetch <= '0;
            r_perf_empty <= '0;
        end else begin
            if (w_pop)       r_perf_fetch <= r_perf_fetch + 1'b1;
            if (stall_req_o) r_perf_empty <= r_perf_empty + 1'b1;
        end
    end

    assign perf_fetch_cnt_o = r_perf_fetch;
    assign perf_empty_cnt_o = r_perf_empty;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model.
// Build with IF_PERF_CNT_EN defined to also check the performance counters.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        ready_i;
    logic        stall_req_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_empty_cnt_o;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .stall_req_o     (stall_req_o)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_empty_cnt_o (perf_empty_cnt_o)
`endif
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] pc; bit drop; } fl_t;

    ent_t        rq[$];   // expected queue contents, head first
    fl_t         fq[$];   // granted addresses awaiting data, oldest first
    logic [31:0] m_pc;
    int          m_perf_fetch;
    int          m_perf_empty;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        fq.delete();
        m_pc         = 32'h0;
        m_perf_fetch = 0;
        m_perf_empty = 0;
    endtask

    task automatic idle_inputs();
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        mem_gnt_i       = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = 32'h0;
        ready_i         = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   64'(mem_req_o),   64'(0));
        check({tag, "_valid"}, 64'(valid_o),     64'(0));
        check({tag, "_pc"},    64'(pc_o),        64'(0));
        check({tag, "_inst"},  64'(inst_o),      64'(0));
        check({tag, "_stall"}, 64'(stall_req_o), 64'(1));
`ifdef IF_PERF_CNT_EN
        check({tag, "_pfetch"}, 64'(perf_fetch_cnt_o), 64'(0));
        check({tag, "_pempty"}, 64'(perf_empty_cnt_o), 64'(0));
`endif
    endtask

    // gmode: 0 = always grant, respond next cycle; 1 = random grant/response; 2 = grant held low
    task automatic cycle(input int gmode, input int ready_pct, input bit br, input logic [31:0] tgt);
        bit   exp_req;
        bit   grant;
        bit   was_empty;
        ent_t e;
        fl_t  f;
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_req = (rq.size() + fq.size()) < DEPTH;
        check("mem_req",  64'(mem_req_o),   64'(exp_req));
        check("mem_addr", 64'(mem_addr_o),  64'(m_pc));
        check("valid",    64'(valid_o),     64'(rq.size() != 0));
        check("stall",    64'(stall_req_o), 64'(rq.size() == 0));
        check("pc",       64'(pc_o),        (rq.size() != 0) ? 64'(rq[0].pc)   : 64'(0));
        check("inst",     64'(inst_o),      (rq.size() != 0) ? 64'(rq[0].inst) : 64'(0));

        mem_gnt_i       = (gmode == 0) ? 1'b1 : (gmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rvalid_i    = (fq.size() != 0) && ((gmode == 0) || ($urandom_range(0, 2) != 0));
        mem_rdata_i     = $urandom;
        ready_i         = ($urandom_range(0, 99) < ready_pct);
        branch_i        = br;
        branch_target_i = tgt;

        @(posedge clk);
        grant     = exp_req && mem_gnt_i;
        was_empty = (rq.size() == 0);
        if (was_empty) m_perf_empty++;
        if (!was_empty && ready_i && !branch_i) begin
            e = rq.pop_front();
            m_perf_fetch++;
            $display("pop  pc=%08h inst=%08h", e.pc, e.inst);
        end
        if (mem_rvalid_i) begin
            f = fq.pop_front();
            if (!f.drop && !branch_i) begin
                e.pc   = f.pc;
                e.inst = mem_rdata_i;
                rq.push_back(e);
            end
        end
        if (grant) begin
            f.pc   = m_pc;
            f.drop = branch_i;
            fq.push_back(f);
        end
        if (branch_i) begin
            foreach (fq[i]) fq[i].drop = 1'b1;
            rq.delete();
            m_pc = tgt;
            $display("redirect to %08h", tgt);
        end else if (grant) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        idle_inputs();
        #1;
        check_reset_state(tag);
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        check_reset_state("por");
        repeat (2) @(posedge clk);

        // Streaming: one instruction per cycle after the two-cycle fill
        for (int k = 0; k < 8; k++) begin
            cycle(0, 100, 1'b0, 32'h0);
            #1;
            if (k >= 1) check("stream_pc", 64'(pc_o), 64'(4 * (k - 1)));
        end

        // ID stalled: queue fills and requests stop
        repeat (10) cycle(0, 0, 1'b0, 32'h0);
        #1;
        check("full_req",   64'(mem_req_o), 64'(0));
        check("full_valid", 64'(valid_o),   64'(1));
        repeat (12) cycle(0, 100, 1'b0, 32'h0);

        // Redirect with grant and response in the same cycle
        cycle(0, 100, 1'b1, 32'h100);
        #1;
        check("br_addr",  64'(mem_addr_o), 64'(32'h100));
        check("br_valid", 64'(valid_o),    64'(0));
        repeat (10) cycle(0, 100, 1'b0, 32'h0);

        // Grant withheld: address must not move
        repeat (3) cycle(2, 100, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("midrst");
            cycle(1, 60, ($urandom_range(0, 19) == 0), $urandom & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < 100; i++) begin
            cycle(1, 95, ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC);
        end

        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", 64'(perf_fetch_cnt_o), 64'(m_perf_fetch));
        check("perf_empty", 64'(perf_empty_cnt_o), 64'(m_perf_empty));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
